// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a valid/ready load
// handshake, selectable bit order and qualified serial output.

module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pl,
  output logic             pl_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             load;

  // Output decode from state/sh/cnt; pl_ready is the only path from inputs
  // and is held low while reset is asserted.
  always_comb begin
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_out   = IDLE_VAL;
    if (state == SHIFT) begin
      ser_valid = 1'b1;
      ser_last  = (cnt == LAST_CNT);
      ser_out   = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    end
    busy     = ser_valid;
    pl_ready = !rst && ((state == IDLE) || (shift_en && ser_last));
    load     = pl && pl_ready;
  end

  // Next-state logic: load on an accepted handshake, otherwise shift toward
  // the output end on enabled edges and fall back to IDLE after the last bit.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    if (load) begin
      state_nxt = SHIFT;
      sh_nxt    = a;
      cnt_nxt   = '0;
    end else if (state == SHIFT && shift_en) begin
      if (ser_last) begin
        state_nxt = IDLE;
      end else begin
        sh_nxt  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State, shift register and bit counter; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: two instances (LSB-first with idle low,
// MSB-first with idle high) driven by the same stimulus and checked against
// a word/bit-index reference model.

module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pl = 1'b0;
  logic [W-1:0] a = '0;
  logic         shift_en = 1'b0;

  logic rdy_l, out_l, val_l, last_l, busy_l;
  logic rdy_m, out_m, val_m, last_m, busy_m;

  int num_checks = 0;
  int num_fails  = 0;

  // Reference model: is a word in flight, which word, which bit is showing.
  bit         m_active = 1'b0;
  bit [W-1:0] m_word = '0;
  int         m_idx = 0;

  // Capture of consumed bits (LSB-first instance, MSB-first instance).
  bit [31:0] cap_l;
  bit [31:0] cap_m;
  int        cap_n;
  int        valid_cycles;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .pl(pl), .pl_ready(rdy_l), .a(a),
    .shift_en(shift_en), .ser_out(out_l), .ser_valid(val_l),
    .ser_last(last_l), .busy(busy_l)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_msb (
    .clk(clk), .rst(rst), .pl(pl), .pl_ready(rdy_m), .a(a),
    .shift_en(shift_en), .ser_out(out_m), .ser_valid(val_m),
    .ser_last(last_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output of both instances with the model.
  task automatic checkAll();
    bit exp_last;
    bit exp_rdy;
    exp_last = m_active && (m_idx == W - 1);
    exp_rdy  = !rst && (!m_active || (shift_en && exp_last));
    checkOutput("lsb_valid", val_l,  m_active);
    checkOutput("lsb_busy",  busy_l, m_active);
    checkOutput("lsb_last",  last_l, exp_last);
    checkOutput("lsb_out",   out_l,  m_active ? m_word[m_idx] : 1'b0);
    checkOutput("lsb_ready", rdy_l,  exp_rdy);
    checkOutput("msb_valid", val_m,  m_active);
    checkOutput("msb_last",  last_m, exp_last);
    checkOutput("msb_out",   out_m,  m_active ? m_word[W-1-m_idx] : 1'b1);
    checkOutput("msb_ready", rdy_m,  exp_rdy);
  endtask

  // Model update for one clock edge with the given inputs.
  task automatic modelStep(input bit p, input bit [W-1:0] w, input bit se);
    bit ready;
    ready = !m_active || (se && m_idx == W - 1);
    if (p && ready) begin
      m_active = 1'b1;
      m_word   = w;
      m_idx    = 0;
    end else if (m_active && se) begin
      if (m_idx == W - 1) m_active = 1'b0;
      else m_idx++;
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, step the
  // model on the rising edge.
  task automatic applyStimulus(input bit p, input bit [W-1:0] w, input bit se);
    pl = p;
    a = w;
    shift_en = se;
    @(negedge clk);
    checkAll();
    if (val_l) valid_cycles++;
    if (val_l && se && cap_n < 32) begin
      cap_l[cap_n] = out_l;
      cap_m[cap_n] = out_m;
      cap_n++;
    end
    @(posedge clk);
    modelStep(p, w, se);
    #1;
  endtask

  // Asynchronous reset raised between edges; outputs must react at once.
  task automatic doReset();
    pl = 1'b0;
    shift_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_active = 1'b0;
    checkOutput("rst_lsb_valid", val_l, 1'b0);
    checkOutput("rst_lsb_busy", busy_l, 1'b0);
    checkOutput("rst_lsb_out", out_l, 1'b0);
    checkOutput("rst_msb_out", out_m, 1'b1);
    checkOutput("rst_ready_low", rdy_l, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_ready_high", rdy_l, 1'b1);
    checkOutput("rst_lsb_last", last_l, 1'b0);
  endtask

  task automatic clearCapture();
    cap_l = '0;
    cap_m = '0;
    cap_n = 0;
    valid_cycles = 0;
  endtask

  initial begin
    doReset();

    // LSB/MSB-first with A5
    clearCapture();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("a5_lsb_bits", cap_l[7:0], 8'hA5);
    checkOutput("a5_msb_bits", cap_m[7:0], 8'hA5);
    checkOutput("a5_duration", valid_cycles, 8);

    // MSB-first order on an asymmetric word
    clearCapture();
    applyStimulus(1'b1, 8'h1E, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("1e_lsb_bits", cap_l[7:0], 8'h1E);
    checkOutput("1e_msb_bits", cap_m[7:0], 8'h78);

    // Stall for 3 cycles after bit 2 of 0F
    clearCapture();
    applyStimulus(1'b1, 8'h0F, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stall_bits", cap_l[7:0], 8'h0F);
    checkOutput("stall_duration", valid_cycles, 11);

    // Back-to-back FF then 00 with pl held high
    clearCapture();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("b2b_bits", cap_l[15:0], 16'h00FF);
    checkOutput("b2b_count", cap_n, 16);
    checkOutput("b2b_no_gap", valid_cycles, 16);

    // Reset at bit 3 of 3C, then a clean 81
    applyStimulus(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    doReset();
    clearCapture();
    applyStimulus(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("restart_bits", cap_l[7:0], 8'h81);
    checkOutput("restart_count", cap_n, 8);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) doReset();
      else applyStimulus($urandom_range(0, 2) != 0, W'($urandom),
                         $urandom_range(0, 3) != 0);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, in configurable bit order. Serial output is qualified by valid and last-bit flags. It is the generalised successor to the fixed 4-bit PISO shift register and is the standard front end for the team's serial transmit paths.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 0, bit order: 0 = bit 0 first; 1 = bit WIDTH-1 first.
- IDLE_VAL, 1'b0, level driven on ser_out when no word is in flight.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pl  in  1  load request (valid).
- pl_ready  out  1  load can be accepted this cycle.
- a  in  WIDTH  parallel word; sampled only on an accepted load.
- shift_en  in  1  advance to the next bit at this edge; ignored in IDLE.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out carries a data bit.
- ser_last  out  1  ser_out is the final bit of the word.
- busy  out  1  word in flight; equals ser_valid.

## Operation
- The block has two states, IDLE and SHIFT. Storage is a WIDTH-bit shift register `sh` and a bit counter `cnt` of width $clog2(WIDTH).
- A load is accepted at an edge where pl && pl_ready. On acceptance, `sh` takes the value of a, `cnt` is set to 0, and the state becomes SHIFT.
- pl_ready = (state==IDLE) || (state==SHIFT && shift_en && ser_last). This is the only combinational input-to-output path.
- In SHIFT:
  - ser_out = sh[0] when MSB_FIRST=0, or sh[WIDTH-1] when MSB_FIRST=1.
  - ser_valid=1.
  - ser_last = (cnt==WIDTH-1).
- On an edge in SHIFT with shift_en=1 and ser_last=0, `sh` shifts toward the output end (zero fill) and `cnt` increments.
- On an edge in SHIFT with shift_en=1 and ser_last=1:
  - If a load is accepted at the same edge, the new word is loaded and the state stays SHIFT (back-to-back, no gap bit).
  - Otherwise the state returns to IDLE.
- In SHIFT with shift_en=0, all state holds and the outputs are stable (stall).
- In IDLE: ser_out=IDLE_VAL, ser_valid=0, ser_last=0, busy=0. shift_en has no effect.
- pl while in SHIFT with pl_ready=0 is ignored. The word is not queued, and the source must hold pl.
- Reset (asynchronous, at any time, including mid-word):
  - state=IDLE, `sh`=0, `cnt`=0.
  - Outputs immediately go to: ser_out=IDLE_VAL, ser_valid=0, ser_last=0, busy=0, pl_ready=1 (once rst deasserts; pl_ready=0 while rst=1).
  - A partially sent word is discarded.

## Timing
- Latency: a load accepted at edge N presents the first bit on ser_out after edge N, during cycle N+1.
- With shift_en held high, bit k is presented in cycle N+1+k. ser_last is high in cycle N+WIDTH.
- Throughput: one word per WIDTH enabled cycles. Back-to-back words have no idle cycle.
- Each stall cycle (shift_en=0) extends the word by exactly one cycle.
- Outputs other than pl_ready are registered or decoded only from state, `sh` and `cnt`.

## Test plan
- Reset check: assert rst mid-sim, asynchronously between edges. Required: ser_valid=0, ser_out=IDLE_VAL and busy=0 immediately, without waiting for an edge.
- LSB-first shifting: WIDTH=8, MSB_FIRST=0, load a=8'hA5, shift_en=1. Required: ser_out sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8, ser_last only in cycle N+8, then IDLE.
- MSB-first shifting: WIDTH=8, MSB_FIRST=1, load 8'hA5. Required: sequence 1,0,1,0,0,1,0,1 reversed relative to LSB order, i.e. bits 7..0 = 1,0,1,0,0,1,0,1.
- Stall: 8'h0F, LSB-first, shift_en low for 3 cycles after bit 2. Required: ser_out holds bit 2 for 4 cycles, the remaining bits are correct, and the total word duration is 11 cycles.
- Back-to-back loads: 8'hFF then 8'h00, with pl held high. Required: the second load is accepted at the ser_last edge, 16 contiguous valid bits, and no ser_valid gap.
- Reset mid-word: rst at bit 3 of 8'h3C, then a new load of 8'h81. Required: clean restart, output 1,0,0,0,0,0,0,1, with no residual bits from 8'h3C.
